// File: rtl/mem_arbiter.sv
// Burst-granular arbiter sharing one main memory between the I-cache (port 0) and D-cache (port 1).
// Optional build macro ARB_PERF_CNT_EN adds saturating grant/wait performance counters.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          rd0,
  input  logic          rd1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          stall0,
  output logic          stall1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_stall,
  output logic          err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1,
  output logic [15:0]   wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic v;
    logic id;
  } ret_t;

  state_t state, next_state;
  logic   rr_last;
  logic   own0, own1;
  ret_t   pipe [MEM_LAT];
  ret_t   tail;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state == OWN0)
        rr_last <= 1'b0;
      else if (next_state == OWN1)
        rr_last <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req0 && req1)
          next_state = rr_last ? OWN0 : OWN1;
        else if (req0)
          next_state = OWN0;
        else if (req1)
          next_state = OWN1;
      end
      OWN0: begin
        if (!lock0 && req1)
          next_state = OWN1;
        else if (!lock0 && !req0)
          next_state = IDLE;
      end
      OWN1: begin
        if (!lock1 && req0)
          next_state = OWN0;
        else if (!lock1 && !req1)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
  always_comb begin
    gnt0      = own0;
    gnt1      = own1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    stall0    = 1'b0;
    stall1    = 1'b0;
    err       = 1'b0;
    if (own0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_rd    = rd0 & ~wr0;
      mem_wr    = wr0;
      stall0    = mem_stall;
      err       = rd0 & wr0;
    end else begin
      stall0 = rd0 | wr0;
      err    = rd0 | wr0;
    end
    if (own1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_rd    = rd1 & ~wr1;
      mem_wr    = wr1;
      stall1    = mem_stall;
      err       = err | (rd1 & wr1);
    end else begin
      stall1 = rd1 | wr1;
      err    = err | rd1 | wr1;
    end
  end

  // Read tags travel with the data latency so returns reach the issuer after ownership moves on.
  // NOTE: the tag pipeline is reset, not just the state, so a reset discards in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= {mem_rd & ~mem_stall, own1};
      for (int i = 1; i < MEM_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tail    = pipe[MEM_LAT-1];
  assign rvalid0 = tail.v & ~tail.id;
  assign rvalid1 = tail.v & tail.id;
  assign rdata   = mem_rdata;

`ifdef ARB_PERF_CNT_EN
  logic enter0, enter1, waiting;

  assign enter0  = (next_state == OWN0) && !own0;
  assign enter1  = (next_state == OWN1) && !own1;
  assign waiting = (req0 & ~own0) | (req1 & ~own1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      wait_cnt <= '0;
    end else begin
      if (enter0 && gnt_cnt0 != 16'hFFFF)
        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (enter1 && gnt_cnt1 != 16'hFFFF)
        gnt_cnt1 <= gnt_cnt1 + 16'd1;
      if (waiting && wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus hand sequences for
// the read-return handoff, stalls and mid-burst reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, rd0, rd1, wr0, wr1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, stall0, stall1, rvalid0, rvalid1;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_stall, err;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [15:0] WD0 = 16'h0D00;
  localparam logic [15:0] WD1 = 16'h1D11;

  mem_arbiter #(.MEM_LAT(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .err(err)
`ifdef ARB_PERF_CNT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .wait_cnt(wait_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        g0, g1, mrd, mwr;
    logic [15:0] maddr, mwd;
    logic        s0, s1, err, rv0, rv1;
  } exp_t;

  typedef struct {
    logic        r0, r1, l0, l1, rd0, wr0, rd1, wr1;
    logic [15:0] a0, a1;
    logic        ms;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];

  // ctl = {req0,req1,lock0,lock1,rd0,wr0,rd1,wr1}; gf = {gnt0,gnt1,mem_rd,mem_wr};
  // sf = {stall0,stall1,err,rvalid0,rvalid1}
  function automatic vec_t mk(input logic [7:0] ctl, input logic [15:0] a0, input logic [15:0] a1,
                              input logic ms, input logic [3:0] gf, input logic [15:0] maddr,
                              input logic [15:0] mwd, input logic [4:0] sf);
    vec_t v;
    {v.r0, v.r1, v.l0, v.l1, v.rd0, v.wr0, v.rd1, v.wr1} = ctl;
    v.a0 = a0;
    v.a1 = a1;
    v.ms = ms;
    v.e  = {gf, maddr, mwd, sf};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; mem_stall = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first cycle with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  function automatic exp_t actual();
    return {gnt0, gnt1, mem_rd, mem_wr, mem_addr, mem_wdata, stall0, stall1, err, rvalid0, rvalid1};
  endfunction

  initial begin
    wdata0 = WD0;
    wdata1 = WD1;
    mem_rdata = 16'hBEEF;

    // Basic single read: req0 pulse at cycle 3, read at cycle 4, data tagged at cycle 6.
    do_reset();
    check("reset_state", {gnt0, gnt1, mem_rd, mem_wr, rvalid0, rvalid1, err, mem_addr, mem_wdata}, '0);
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      idle_inputs();
      if (c == 3) req0 = 1;
      if (c == 4) begin lock0 = 1; rd0 = 1; addr0 = 16'h1230; end
      if (c == 5 || c == 6) lock0 = 1;
      @(negedge clk);
      if (c == 3) check("gnt0_not_early", gnt0, 1'b0);
      if (c == 4) check("first_read", {gnt0, mem_rd, mem_addr}, {1'b1, 1'b1, 16'h1230});
      if (c == 5) check("rvalid_not_early", {rvalid0, rvalid1}, 2'b00);
      if (c == 6) check("rvalid0_lat", {rvalid0, rvalid1, rdata}, {2'b10, 16'hBEEF});
      if (c == 7) check("rvalid_one_shot", {rvalid0, rvalid1}, 2'b00);
    end

    // Cycle-by-cycle trace: tie, handoff without idle, tie alternation, protocol errors, stalls.
    tbl.push_back(mk(8'b00000000, 16'h0000, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 5'b00000));
    tbl.push_back(mk(8'b11000000, 16'h0000, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 5'b00000));
    tbl.push_back(mk(8'b01100000, 16'h0000, 16'h0000, 0, 4'b1000, 16'h0000, WD0,      5'b00000));
    tbl.push_back(mk(8'b01000000, 16'h0000, 16'h0000, 0, 4'b1000, 16'h0000, WD0,      5'b00000));
    tbl.push_back(mk(8'b00010010, 16'h0000, 16'h8000, 0, 4'b0110, 16'h8000, WD1,      5'b00000));
    tbl.push_back(mk(8'b00000000, 16'h0000, 16'h0000, 0, 4'b0100, 16'h0000, WD1,      5'b00000));
    tbl.push_back(mk(8'b11000000, 16'h0000, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 5'b00001));
    tbl.push_back(mk(8'b01100001, 16'h0000, 16'h0000, 0, 4'b1000, 16'h0000, WD0,      5'b01100));
    tbl.push_back(mk(8'b00101100, 16'h0040, 16'h0000, 0, 4'b1001, 16'h0040, WD0,      5'b00100));
    tbl.push_back(mk(8'b00101000, 16'h0050, 16'h0000, 1, 4'b1010, 16'h0050, WD0,      5'b10000));
    tbl.push_back(mk(8'b00101000, 16'h0050, 16'h0000, 0, 4'b1010, 16'h0050, WD0,      5'b00000));
    tbl.push_back(mk(8'b00100000, 16'h0000, 16'h0000, 0, 4'b1000, 16'h0000, WD0,      5'b00000));
    tbl.push_back(mk(8'b00000000, 16'h0000, 16'h0000, 0, 4'b1000, 16'h0000, WD0,      5'b00010));
    tbl.push_back(mk(8'b00001000, 16'h0000, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 5'b10100));
    tbl.push_back(mk(8'b00000000, 16'h0000, 16'h0000, 0, 4'b0000, 16'h0000, 16'h0000, 5'b00000));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) next_cycle();
      {req0, req1, lock0, lock1, rd0, wr0, rd1, wr1} =
        {tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, tbl[i].rd0, tbl[i].wr0, tbl[i].rd1, tbl[i].wr1};
      addr0 = tbl[i].a0;
      addr1 = tbl[i].a1;
      mem_stall = tbl[i].ms;
      @(negedge clk);
      check($sformatf("vec%0d", i), actual(), tbl[i].e);
    end

    // Port 1 bursts four reads then hands over to port 0; returns still go to port 1.
    do_reset();
    req1 = 1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      idle_inputs();
      if (c >= 1 && c <= 4) begin
        rd1 = 1;
        addr1 = 16'h8000 + 16'(2 * (c - 1));
        lock1 = (c < 4);
        req0 = (c == 4);
      end
      if (c >= 5) lock0 = 1;
      @(negedge clk);
      if (c == 1) check("burst_gnt1", {gnt0, gnt1, mem_rd, mem_addr}, {3'b011, 16'h8000});
      if (c == 5) check("handoff_gnt0", {gnt0, gnt1}, 2'b10);
      check($sformatf("burst_rv_c%0d", c), {rvalid0, rvalid1}, {1'b0, (c >= 3 && c <= 6)});
    end

    // Reset in the middle of a port 0 burst with two reads in flight.
    do_reset();
    req0 = 1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      idle_inputs();
      lock0 = 1;
      rd0 = 1;
      addr0 = 16'h0100 + 16'(2 * (c - 1));
    end
    #1;
    check("pre_reset_inflight", {gnt0, mem_rd, rvalid0}, 3'b111);
    rst = 0;
    #1;
    check("reset_drops", {gnt0, gnt1, mem_rd, mem_wr, rvalid0, rvalid1}, '0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      check($sformatf("no_stale_rv%0d", c), {gnt0, gnt1, rvalid0, rvalid1}, 4'b0000);
    end
`ifdef ARB_PERF_CNT_EN
    check("perf_cnt_reset", {gnt_cnt0, gnt_cnt1, wait_cnt}, '0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single four-bank main memory between the instruction-cache FSM (port 0) and the data-cache FSM (port 1).
- Grants are burst-granular: the owner holds the memory for a whole fill or writeback by asserting lock.
- Forwards the owner's rd/wr/addr/wdata to memory and returns mem_stall to the owner.
- Tags every accepted read so the returning data is flagged valid only to the requester that issued it, even after ownership has changed.

Parameters:
- MEM_LAT, 2: cycles from an accepted mem_rd to valid mem_rdata.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  request for memory ownership.
- lock0, lock1  in  1  hold ownership (burst in progress).
- rd0, rd1  in  1  read strobe; honoured only while granted.
- wr0, wr1  in  1  write strobe; honoured only while granted.
- addr0, addr1  in  AW  access address.
- wdata0, wdata1  in  DW  write data.
- gnt0, gnt1  out  1  registered ownership grant.
- stall0, stall1  out  1  access not accepted this cycle.
- rvalid0, rvalid1  out  1  rdata belongs to this port this cycle.
- rdata  out  DW  mem_rdata, passed through.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.
- mem_stall  in  1  memory bank busy; access rejected.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- State machine: IDLE, OWN0, OWN1, held in a registered state register. A last-owner bit rr_last is also registered.
- Reset values (rst low, asynchronous):
  - State = IDLE; rr_last = 1, so port 0 wins the first tie.
  - Return pipeline cleared.
  - gnt0/1 = 0, mem_rd = mem_wr = 0, rvalid0/1 = 0, err = 0.
  - mem_addr/mem_wdata = 0.
  - Reset mid-burst drops all in-flight reads; no rvalid is produced for them.
- IDLE:
  - Only req0 → OWN0. Only req1 → OWN1.
  - Both → the port that is not rr_last.
  - Neither → stay.
- OWNx:
  - gntx = 1 for the whole state.
  - If lockx | reqx, and the other port is not requesting → stay.
  - If lockx = 0 and the other port requests → switch directly to OWNy, with no idle cycle.
  - If lockx = 0, reqx = 0 and the other port is idle → IDLE.
  - rr_last = x is loaded on every entry to OWNx.
- Latency: a request in cycle N is seen as gnt in cycle N+1 at the earliest.
- Forwarding (combinational, from the owner only):
  - mem_addr, mem_wdata = owner's addr/wdata.
  - mem_rd = rdx & ~wrx; mem_wr = wrx.
  - If rdx & wrx both assert: write wins, rd is suppressed, err pulses.
- Non-owner and IDLE:
  - mem_rd = mem_wr = 0.
  - Any rd/wr from a non-owner port is dropped with stall = 1 and err pulses; it is never queued.
- Stall:
  - stallx = mem_stall while x owns.
  - stallx = rdx | wrx while x does not own.
  - stallx = 0 otherwise.
- Return pipeline:
  - MEM_LAT-deep shift register of {v, id}.
  - Push v = mem_rd & ~mem_stall, id = current owner, every cycle.
  - rvalidx = tail.v & (tail.id == x).
  - Reads in flight when ownership changes still return to the issuer.
- lock held with req low is legal; ownership persists until lock falls.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs gnt_cnt0, gnt_cnt1, wait_cnt, each 16 bits and saturating at 0xFFFF, all reset to 0.
  - gnt_cntx increments on each entry to OWNx.
  - wait_cnt increments every cycle in which a port has req high and is not the owner.
- Not defined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset release, req0 pulses at cycle 3 → gnt0 = 1 at cycle 4; rd0 with addr0 = 0x1230 at cycle 4 → mem_rd = 1, mem_addr = 0x1230; rvalid0 = 1 at cycle 6; rvalid1 stays 0.
- req0 and req1 both rise in the same cycle from IDLE after reset → port 0 granted. After lock0 falls with req1 still high → gnt1 next cycle, with no IDLE cycle. Repeat the tie → port 0 granted again (alternation).
- Port 1 owns and issues 4 reads at 0x8000/2/4/6, drops lock1 after the last, and port 0 is granted next cycle → all four rvalid1 pulses still arrive at +2 cycles each; rvalid0 stays 0.
- mem_stall = 1 during an owner read → stallx = 1 and no pipeline push (no rvalid 2 cycles later); retry with mem_stall = 0 → rvalid follows.
- Non-owner asserts wr1 while port 0 owns → mem_wr unaffected, stall1 = 1, err pulses one cycle. Owner asserts rd0 and wr0 together → mem_wr = 1, mem_rd = 0, err = 1.
- rst driven low mid-burst with 2 reads in flight → gnt/mem_rd/rvalid drop immediately, with no rvalid after release. With ARB_PERF_CNT_EN defined, the counters read 0.
